// File: rtl/adder_8bit.sv
// ============================================================================
// Module   : adder_8bit
// Purpose  : Registered 8-bit unsigned ripple-carry adder with 9-bit sum and
//            valid flag. Define ADDER_8BIT_INREG_EN to add an input register
//            stage (latency 2 instead of 1).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] out,
    output logic       out_valid
);

    localparam int unsigned c_WIDTH = 8;

    logic [c_WIDTH-1:0] w_a;
    logic [c_WIDTH-1:0] w_b;
    logic               w_valid;
    logic [c_WIDTH-1:0] w_sum;
    logic [c_WIDTH:0]   w_carry;

`ifdef ADDER_8BIT_INREG_EN
    logic [c_WIDTH-1:0] r_a;
    logic [c_WIDTH-1:0] r_b;
    logic               r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_a     <= a;
            r_b     <= b;
            r_valid <= in_valid;
        end
    end

    assign w_a     = r_a;
    assign w_b     = r_b;
    assign w_valid = r_valid;
`else
    assign w_a     = a;
    assign w_b     = b;
    assign w_valid = in_valid;
`endif

    // Ripple chain: each cell produces its sum bit and a majority carry.
    assign w_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < c_WIDTH; i++) begin : g_fa
            assign w_sum[i]     = w_a[i] ^ w_b[i] ^ w_carry[i];
            assign w_carry[i+1] = (w_a[i] & w_b[i]) |
                                  (w_a[i] & w_carry[i]) |
                                  (w_b[i] & w_carry[i]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= w_valid;
            if (w_valid) begin
                out <= {w_carry[c_WIDTH], w_sum};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_8bit.sv
// ============================================================================
// Module   : tb_adder_8bit
// Purpose  : Self-checking bench for adder_8bit against a latency-queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_8bit;

`ifdef ADDER_8BIT_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] out;
    logic       out_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit v;
        int s;
    } ent_t;

    ent_t hist[$];
    int   exp_out;
    bit   exp_v;

    adder_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0;
        e.s = 0;
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back(e);
        exp_out = 0;
        exp_v   = 1'b0;
    endtask

    // Drive one operand set, clock it, and advance the model by one edge.
    task automatic step(input bit v, input int x, input int y);
        ent_t e;
        in_valid = v;
        a = x[7:0];
        b = y[7:0];
        @(posedge clk);
        #1;
        e.v = v;
        e.s = (x & 255) + (y & 255);
        hist.push_back(e);
        while (hist.size() > LAT) void'(hist.pop_front());
        exp_v = hist[0].v;
        if (exp_v) exp_out = hist[0].s;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        a = 8'hA5;
        b = 8'h3C;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out !== 9'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: out=%0d valid=%b, want out=0 valid=0", out, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== 9'd0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: out=%0d valid=%b, want out=0 valid=0", out, out_valid);
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_directed();
        int pa[8] = '{108, 237, 175, 253, 0, 255, 255, 128};
        int pb[8] = '{82, 114, 82, 66, 0, 255, 1, 128};
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) step(1'b1, pa[i], pb[i]);
            else step(1'b0, 0, 0);
            checks++;
            if (out_valid !== exp_v || (exp_v && out !== exp_out[8:0])) begin
                errors++;
                $display("FAIL directed[%0d]: out=%0d valid=%b, want out=%0d valid=%b",
                         i, out, out_valid, exp_out, exp_v);
            end
        end
        checks++;
        if (out !== 9'd256) begin
            errors++;
            $display("FAIL directed_last: out=%0d, want 256", out);
        end
    endtask

    task automatic test_hold();
        step(1'b1, 10, 20);
        for (int i = 0; i < 3 + LAT - 1; i++) step(1'b0, 255, 255);
        checks++;
        if (out !== 9'd30 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold: out=%0d valid=%b, want out=30 valid=0", out, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1;
        a = 8'd200;
        b = 8'd100;
        if (LAT == 2) step(1'b1, 200, 100);
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out !== 9'd0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset[%0d]: out=%0d valid=%b, want out=0 valid=0", i, out, out_valid);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        step(1'b1, 1, 2);
        for (int i = 0; i < LAT - 1; i++) step(1'b0, 0, 0);
        checks++;
        if (out !== 9'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL resume: out=%0d valid=%b, want out=3 valid=1", out, out_valid);
        end
        step(1'b0, 0, 0);
        for (int i = 0; i < LAT; i++) step(1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            checks++;
            if (out_valid !== exp_v || out !== exp_out[8:0]) begin
                errors++;
                $display("FAIL random[%0d]: out=%0d valid=%b, want out=%0d valid=%b",
                         i, out, out_valid, exp_out, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
